bcd_countdown_mmss: RTL and testbench

- Two-stage BCD mm:ss countdown timer built from cascaded mod-60 down-counters with a borrow chain.
- It is the decrementing counterpart of the team's mod-60 up-counter with carry.
- Run control is a small state machine: preset load, start, pause, done.
- Sits beside the clock/stopwatch datapath and drives the 7-seg display mux directly with BCD digits.

---
 rtl/bcd_countdown_mmss_pkg.sv | 22 ++
 rtl/bcd_countdown_mmss_down60.sv | 33 +++
 rtl/bcd_countdown_mmss.sv | 140 ++++++++++++++
 tb/tb_bcd_countdown_mmss.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_mmss_pkg.sv
// Shared types and constants for the BCD mm:ss countdown timer.
// Holds the run-control state encoding, the BCD digit type and the preset range check.
package bcd_countdown_mmss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t ONES_MAX     = 4'd9;

    // A {tens,ones} BCD pair is legal when ones <= 9 and tens <= tens_max.
    function automatic logic bcd_pair_ok(input logic [7:0] val, input bcd_t tens_max);
        return (val[3:0] <= ONES_MAX) && (val[7:4] <= tens_max);
    endfunction

endpackage

// File: rtl/bcd_countdown_mmss_down60.sv
// Single mod-60 style BCD down-counter stage with synchronous load and borrow out.
// Wraps 00 to {tens_max,9}; bout flags the cycle an enabled decrement leaves 00.
module bcd_down60
    import bcd_countdown_mmss_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] data,
    input  bcd_t       tens_max,
    output logic [7:0] q,
    output logic       bout
);

    assign bout = en && (q == 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 8'h00;
        end else if (load) begin
            q <= data;
        end else if (en) begin
            if (q[3:0] == 4'd0) begin
                q[3:0] <= ONES_MAX;
                q[7:4] <= (q[7:4] == 4'd0) ? tens_max : q[7:4] - 4'd1;
            end else begin
                q[3:0] <= q[3:0] - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_mmss.sv
// BCD mm:ss countdown timer: two cascaded BCD down stages plus load/start/pause/done control.
// Define BCD_COUNTDOWN_AUTO_RELOAD_EN to restart from the preset after reaching 00:00 instead of stopping.
module bcd_countdown_mmss
    import bcd_countdown_mmss_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] data_min,
    input  logic [7:0] data_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] qmin,
    output logic [7:0] qsec,
    output logic       bout,
    output logic       done,
    output logic       load_err,
    output logic       running
);

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    localparam bcd_t MIN_TENS = bcd_t'(MIN_TENS_MAX);

    state_t     state, state_next;
    logic [7:0] preset_min, preset_sec;
    logic [7:0] ld_min, ld_sec;
    logic       ld, preset_we, tick_en, done_set, err_set;
    logic       sec_bout;
    logic       load_ok, cnt_zero, cnt_one, preset_zero;

    assign load_ok     = bcd_pair_ok(data_sec, SEC_TENS_MAX) && bcd_pair_ok(data_min, MIN_TENS);
    assign cnt_zero    = (qmin == 8'h00) && (qsec == 8'h00);
    assign cnt_one     = (qmin == 8'h00) && (qsec == 8'h01);
    assign preset_zero = (preset_min == 8'h00) && (preset_sec == 8'h00);

    always_comb begin
        state_next = state;
        ld         = 1'b0;
        ld_min     = data_min;
        ld_sec     = data_sec;
        preset_we  = 1'b0;
        tick_en    = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            RUN: begin
                if (pause) begin
                    state_next = PAUSE;
                end else if (tick) begin
                    // Only reachable with auto-reload: the tick after the terminal one restarts the period.
                    if (AUTO_RELOAD && cnt_zero && !preset_zero) begin
                        ld     = 1'b1;
                        ld_min = preset_min;
                        ld_sec = preset_sec;
                    end else begin
                        tick_en = 1'b1;
                        if (cnt_one) begin
                            done_set = 1'b1;
                            if (!(AUTO_RELOAD && !preset_zero)) state_next = DONE;
                        end
                    end
                end
            end
            default: begin
                if (load) begin
                    if (load_ok) begin
                        ld         = 1'b1;
                        preset_we  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (start && !(pause && state == PAUSE)) begin
                    if (state == DONE) begin
                        if (!preset_zero) begin
                            ld         = 1'b1;
                            ld_min     = preset_min;
                            ld_sec     = preset_sec;
                            state_next = RUN;
                        end
                    end else if (!cnt_zero) begin
                        state_next = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            preset_min <= 8'h00;
            preset_sec <= 8'h00;
            done       <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= done_set;
            load_err <= err_set;
            if (preset_we) begin
                preset_min <= data_min;
                preset_sec <= data_sec;
            end
        end
    end

    assign running = (state == RUN);
    assign bout    = tick && running && (qsec == 8'h00);

    bcd_down60 u_sec (
        .clk      (clk),
        .rst      (reset),
        .en       (tick_en),
        .load     (ld),
        .data     (ld_sec),
        .tens_max (SEC_TENS_MAX),
        .q        (qsec),
        .bout     (sec_bout)
    );

    bcd_down60 u_min (
        .clk      (clk),
        .rst      (reset),
        .en       (sec_bout),
        .load     (ld),
        .data     (ld_min),
        .tens_max (MIN_TENS),
        .q        (qmin),
        .bout     ()
    );

endmodule

// File: tb/tb_bcd_countdown_mmss.sv
// Directed bench for bcd_countdown_mmss: reset, countdown/borrow, done, load checks, pause priority, async reset.
module tb_bcd_countdown_mmss;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data_min = 8'h00;
    logic [7:0] data_sec = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] qmin, qsec;
    logic       bout, done, load_err, running;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_countdown_mmss #(.MIN_TENS_MAX(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .data_min (data_min),
        .data_sec (data_sec),
        .start    (start),
        .pause    (pause),
        .qmin     (qmin),
        .qsec     (qsec),
        .bout     (bout),
        .done     (done),
        .load_err (load_err),
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load = 1'b1; data_min = m; data_sec = s;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_sec [5];
        exp_sec[0] = 8'h04; exp_sec[1] = 8'h03; exp_sec[2] = 8'h02;
        exp_sec[3] = 8'h01; exp_sec[4] = 8'h00;

        #2;
        chk("rst_qmin", qmin, 8'h00);
        chk("rst_qsec", qsec, 8'h00);
        chk("rst_running", 8'(running), 8'h00);
        chk("rst_done", 8'(done), 8'h00);
        chk("rst_load_err", 8'(load_err), 8'h00);
        cyc(); cyc();
        reset = 1'b0;
        cyc();

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        do_load(8'h00, 8'h02);
        do_start();
        chk("ar_running", 8'(running), 8'h01);
        do_tick();
        chk("ar_t1_qsec", qsec, 8'h01);
        do_tick();
        chk("ar_t2_qsec", qsec, 8'h00);
        chk("ar_t2_done", 8'(done), 8'h01);
        chk("ar_t2_running", 8'(running), 8'h01);
        do_tick();
        chk("ar_t3_qsec", qsec, 8'h02);
        chk("ar_t3_done", 8'(done), 8'h00);
        do_tick();
        chk("ar_t4_qsec", qsec, 8'h01);
        do_tick();
        chk("ar_t5_qsec", qsec, 8'h00);
        chk("ar_t5_qmin", qmin, 8'h00);
        chk("ar_t5_done", 8'(done), 8'h01);
        chk("ar_t5_running", 8'(running), 8'h01);
`else
        // Countdown with borrow into minutes.
        do_load(8'h01, 8'h05);
        chk("ld_qmin", qmin, 8'h01);
        chk("ld_qsec", qsec, 8'h05);
        chk("ld_running", 8'(running), 8'h00);
        do_start();
        chk("start_running", 8'(running), 8'h01);
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            #1;
            if (i == 0) chk("bout_idle", 8'(bout), 8'h00);
            cyc();
            tick = 1'b0;
            chk($sformatf("cnt_qsec_%0d", i), qsec, exp_sec[i]);
            chk($sformatf("cnt_qmin_%0d", i), qmin, 8'h01);
        end
        tick = 1'b1;
        #1;
        chk("bout_borrow", 8'(bout), 8'h01);
        cyc();
        tick = 1'b0;
        chk("borrow_qmin", qmin, 8'h00);
        chk("borrow_qsec", qsec, 8'h59);

        // Load in RUN is ignored.
        do_load(8'h12, 8'h34);
        chk("runld_qmin", qmin, 8'h00);
        chk("runld_qsec", qsec, 8'h59);
        chk("runld_err", 8'(load_err), 8'h00);
        chk("runld_running", 8'(running), 8'h01);
        do_pause();

        // Terminal count and restart from DONE.
        do_load(8'h00, 8'h02);
        do_start();
        do_tick();
        chk("term_t1_qsec", qsec, 8'h01);
        chk("term_t1_done", 8'(done), 8'h00);
        do_tick();
        chk("term_qsec", qsec, 8'h00);
        chk("term_done", 8'(done), 8'h01);
        chk("term_running", 8'(running), 8'h00);
        cyc();
        chk("term_done_clr", 8'(done), 8'h00);
        do_tick();
        chk("term_hold_qsec", qsec, 8'h00);
        chk("term_hold_qmin", qmin, 8'h00);
        do_start();
        chk("restart_qsec", qsec, 8'h02);
        chk("restart_running", 8'(running), 8'h01);

        // Rejected loads leave count and preset alone.
        do_pause();
        do_load(8'h00, 8'h6A);
        chk("bad_sec_err", 8'(load_err), 8'h01);
        chk("bad_sec_qsec", qsec, 8'h02);
        cyc();
        chk("bad_sec_err_clr", 8'(load_err), 8'h00);
        do_start();
        do_tick();
        do_tick();
        chk("bad_sec_done", 8'(done), 8'h01);
        do_start();
        chk("bad_sec_preset", qsec, 8'h02);
        do_pause();
        do_load(8'h60, 8'h00);
        chk("bad_min_err", 8'(load_err), 8'h01);
        chk("bad_min_qmin", qmin, 8'h00);
        chk("bad_min_qsec", qsec, 8'h02);

        // Pause priority over tick and start.
        do_load(8'h03, 8'h10);
        do_start();
        tick = 1'b1; pause = 1'b1;
        cyc();
        tick = 1'b0; pause = 1'b0;
        chk("pz_running", 8'(running), 8'h00);
        chk("pz_qmin", qmin, 8'h03);
        chk("pz_qsec", qsec, 8'h10);
        for (int i = 0; i < 3; i++) do_tick();
        chk("pz_ticks_qsec", qsec, 8'h10);
        start = 1'b1; pause = 1'b1;
        cyc();
        start = 1'b0; pause = 1'b0;
        chk("pz_both_running", 8'(running), 8'h00);
        do_start();
        chk("pz_resume_running", 8'(running), 8'h01);
        do_load(8'h05, 8'h00);
        chk("pz_runld_qmin", qmin, 8'h03);
        do_tick();
        chk("pz_tick_qsec", qsec, 8'h09);
        chk("pz_tick_qmin", qmin, 8'h03);

        // Asynchronous reset between edges.
        do_pause();
        do_load(8'h12, 8'h34);
        do_start();
        chk("ar_pre_qmin", qmin, 8'h12);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_qmin", qmin, 8'h00);
        chk("arst_qsec", qsec, 8'h00);
        chk("arst_running", 8'(running), 8'h00);
        chk("arst_done", 8'(done), 8'h00);
        cyc();
        reset = 1'b0;
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
